uart_tx_frame_seq: RTL
======================

Name: uart_tx_frame_seq

Overview:
Parametrised UART transmit frame sequencer. It replaces the fixed 4-input registered output select with a complete frame engine:
- one-entry holding buffer with valid/ready handshake
- start / data / parity / stop sequencing, with parity mode and stop-bit count chosen per frame
- registered, glitch-free serial output

It sits between the system-side TX data path and the TX pin. Bit timing comes from an external baud-tick enable in the same clock domain.

Parameters:
DATA_WIDTH, 8, data bits per frame (legal 5..9), sent LSB first
IDLE_LEVEL, 1'b1, line level in idle and during stop bits; the start bit is ~IDLE_LEVEL

Ports:
CLK  input  1  system clock
RST  input  1  synchronous, active-high reset
BAUD_TICK  input  1  one-CLK pulse per bit period; all line transitions occur only on CLK edges where BAUD_TICK=1
P_DATA  input  DATA_WIDTH  frame payload
DATA_VALID  input  1  payload/config valid
PAR_EN  input  1  1 = append parity bit
PAR_TYP  input  1  0 = even, 1 = odd
STOP2  input  1  1 = two stop bits, 0 = one
READY  output  1  holding buffer empty; transfer occurs when DATA_VALID & READY
TX_OUT  output  1  serial line, registered
BUSY  output  1  frame in progress or buffer occupied
FRAME_DONE  output  1  one-CLK pulse when the last stop bit ends

Behaviour:
- Reset (RST=1 at a CLK edge, in any state):
  - state=IDLE, buffer empty, bit counter=0
  - TX_OUT=IDLE_LEVEL, FRAME_DONE=0
  - READY=1 and BUSY=0 after that edge
  - An in-flight frame is aborted, with no FRAME_DONE. All inputs are ignored while RST=1.
- READY = ~buf_full (combinational). BUSY = (state!=IDLE) | buf_full.
- Accept: on an edge with DATA_VALID & READY, the buffer captures P_DATA, PAR_EN, PAR_TYP and STOP2. Parity is computed from the buffered data: even = ^data, odd = ~^data. Config is per frame and may change between frames.
- FSM states: IDLE, START, DATA, PARITY, STOP. State changes only on edges with BAUD_TICK=1.
  - IDLE: if BAUD_TICK & buf_full -> START, TX_OUT=~IDLE_LEVEL. The buffer moves to the shift register and buf_full clears on that edge. The first start edge therefore occurs at the first BAUD_TICK edge after acceptance; the earliest is the edge after acceptance, never the acceptance edge itself.
  - START: on tick -> DATA, TX_OUT=data[0], bit counter=1.
  - DATA: on tick, if counter<DATA_WIDTH -> TX_OUT=data[counter], counter++.
    - If counter=DATA_WIDTH: go to PARITY (TX_OUT=parity) when PAR_EN, else STOP (TX_OUT=IDLE_LEVEL).
  - PARITY: on tick -> STOP, TX_OUT=IDLE_LEVEL.
  - STOP: holds 1 bit period (STOP2=0) or 2 (STOP2=1), counted with the bit counter.
    - At the tick ending the last stop bit: FRAME_DONE=1 for that cycle.
    - If buf_full: go directly to START with TX_OUT=~IDLE_LEVEL (back-to-back, no idle gap) and load the buffer.
    - Else: go to IDLE, TX_OUT stays IDLE_LEVEL.
- Every bit is exactly one tick period. Frame length = 1 + DATA_WIDTH + PAR_EN + 1 + STOP2 tick periods.
- Accept and buffer-load never coincide, since acceptance needs the buffer empty and load needs it full. A new frame may be accepted while the previous one is shifting. DATA_VALID with READY=0 is held off with no loss.
- BAUD_TICK=0 forever: the FSM freezes with TX_OUT stable.

Decomposition:
- Shared package uart_tx_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - PAR_EVEN/PAR_ODD constants
  - function for the bit-counter width, $clog2(DATA_WIDTH+1)
- One sub-module, uart_tx_parity_calc: combinational, DATA_WIDTH-parametrised, (data, par_typ) -> parity bit. It is instantiated on the buffer output.
- Everything else stays in one module.

Test Plan:
- Basic frame, 8 bits, one tick every 4 CLKs. Accept P_DATA=0xA5 with PAR_EN=1, PAR_TYP=0, STOP2=0.
  -> TX_OUT per tick: 0,1,0,1,0,0,1,0,1,0(parity),1. FRAME_DONE pulses once at the end of the 11th bit. BUSY high from acceptance until then.
- Odd parity with two stop bits. 0xA5, PAR_TYP=1, STOP2=1 -> parity bit=1. Stop level is held 2 tick periods (12 ticks total).
- No parity, DATA_WIDTH=5 instance. Accept 0x13 with PAR_EN=0 -> bits 0,1,1,0,0,1,1 (7 ticks). No parity bit.
- Back-to-back. Accept 0x55, then offer 0x0F with DATA_VALID held high.
  -> READY drops and 0x0F is accepted on the edge after 0x55 is loaded into the shift register.
  -> The start bit of 0x0F follows the last stop bit of 0x55 with no idle tick.
- Reset mid-frame: assert RST for 1 CLK during DATA bit 3.
  -> The next edge gives TX_OUT=1, READY=1, BUSY=0, and no FRAME_DONE. A fresh 0xA5 frame then transmits correctly.
- Tick stall: hold BAUD_TICK=0 for 50 CLKs mid-frame -> TX_OUT constant. The frame resumes unchanged when ticks restart.

Source files
------------

// File: rtl/uart_tx_frame_seq_pkg.sv
// ============================================================================
// Module      : uart_tx_pkg
// Description : Shared types and helpers for the UART TX frame sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Counter must hold the value DATA_WIDTH itself, not just DATA_WIDTH-1.
  function automatic int cnt_width(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_frame_seq_if.sv
// ============================================================================
// Module      : uart_tx_frame_seq_if
// Description : Payload/config valid-ready handshake into the TX sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_frame_seq_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  STOP2;
  logic                  READY;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2,
    input  READY
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2,
    output READY
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_frame_seq_parity_calc.sv
// ============================================================================
// Module      : uart_tx_parity_calc
// Description : Combinational even/odd parity over a DATA_WIDTH payload.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_par_typ,
  output logic                  o_parity
);

  always_comb begin
    o_parity = (i_par_typ == PAR_ODD) ? ~^i_data : ^i_data;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_frame_seq.sv
// ============================================================================
// Module      : uart_tx_frame_seq
// Description : UART TX frame engine: holding buffer, start/data/parity/stop
//               sequencing on an external baud tick, registered serial output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_frame_seq
  import uart_tx_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                BAUD_TICK,
  uart_tx_frame_seq_if.slave  bus,
  output logic                TX_OUT,
  output logic                BUSY,
  output logic                FRAME_DONE
);

  localparam int              CW         = cnt_width(DATA_WIDTH);
  localparam logic [2:0]      c_IDLE     = ST_IDLE;
  localparam logic [2:0]      c_START    = ST_START;
  localparam logic [2:0]      c_DATA     = ST_DATA;
  localparam logic [2:0]      c_PARITY   = ST_PARITY;
  localparam logic [2:0]      c_STOP     = ST_STOP;
  localparam logic [CW-1:0]   c_CNT_LAST = CW'(DATA_WIDTH);

  // Holding buffer
  logic                  r_buf_full;
  logic [DATA_WIDTH-1:0] r_buf_data;
  logic                  r_buf_par_en;
  logic                  r_buf_par_typ;
  logic                  r_buf_stop2;

  // Active frame
  logic [2:0]            r_state;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_sh_data;
  logic                  r_sh_par_en;
  logic                  r_sh_parity;
  logic                  r_sh_stop2;
  logic                  r_tx;
  logic                  r_done;

  logic                  w_accept;
  logic                  w_stop_last;
  logic                  w_load;
  logic                  w_buf_parity;

  uart_tx_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .i_data    (r_buf_data),
    .i_par_typ (r_buf_par_typ),
    .o_parity  (w_buf_parity)
  );

  always_comb begin
    w_accept    = bus.DATA_VALID & ~r_buf_full;
    w_stop_last = (r_state == c_STOP) & (r_cnt == CW'(r_sh_stop2));
    w_load      = BAUD_TICK & r_buf_full & ((r_state == c_IDLE) | w_stop_last);
  end

  assign bus.READY  = ~r_buf_full;
  assign BUSY       = (r_state != c_IDLE) | r_buf_full;
  assign TX_OUT     = r_tx;
  assign FRAME_DONE = r_done;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_buf_full    <= 1'b0;
      r_buf_data    <= '0;
      r_buf_par_en  <= 1'b0;
      r_buf_par_typ <= 1'b0;
      r_buf_stop2   <= 1'b0;
      r_state       <= c_IDLE;
      r_cnt         <= '0;
      r_sh_data     <= '0;
      r_sh_par_en   <= 1'b0;
      r_sh_parity   <= 1'b0;
      r_sh_stop2    <= 1'b0;
      r_tx          <= IDLE_LEVEL;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // Accept needs an empty buffer, load needs a full one: never both.
      if (w_accept) begin
        r_buf_full    <= 1'b1;
        r_buf_data    <= bus.P_DATA;
        r_buf_par_en  <= bus.PAR_EN;
        r_buf_par_typ <= bus.PAR_TYP;
        r_buf_stop2   <= bus.STOP2;
      end else if (w_load) begin
        r_buf_full  <= 1'b0;
        r_sh_data   <= r_buf_data;
        r_sh_par_en <= r_buf_par_en;
        r_sh_parity <= w_buf_parity;
        r_sh_stop2  <= r_buf_stop2;
      end

      if (BAUD_TICK) begin
        case (r_state)
          c_IDLE: begin
            if (r_buf_full) begin
              r_state <= c_START;
              r_tx    <= ~IDLE_LEVEL;
            end
          end
          c_START: begin
            r_state   <= c_DATA;
            r_tx      <= r_sh_data[0];
            r_sh_data <= r_sh_data >> 1;
            r_cnt     <= CW'(1);
          end
          c_DATA: begin
            if (r_cnt != c_CNT_LAST) begin
              r_tx      <= r_sh_data[0];
              r_sh_data <= r_sh_data >> 1;
              r_cnt     <= r_cnt + CW'(1);
            end else if (r_sh_par_en) begin
              r_state <= c_PARITY;
              r_tx    <= r_sh_parity;
            end else begin
              r_state <= c_STOP;
              r_tx    <= IDLE_LEVEL;
              r_cnt   <= '0;
            end
          end
          c_PARITY: begin
            r_state <= c_STOP;
            r_tx    <= IDLE_LEVEL;
            r_cnt   <= '0;
          end
          c_STOP: begin
            if (w_stop_last) begin
              r_done <= 1'b1;
              r_cnt  <= '0;
              if (r_buf_full) begin
                r_state <= c_START;
                r_tx    <= ~IDLE_LEVEL;
              end else begin
                r_state <= c_IDLE;
                r_tx    <= IDLE_LEVEL;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          default: begin
            r_state <= c_IDLE;
            r_tx    <= IDLE_LEVEL;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
